// File: rtl/tpu_seq_pkg.sv
// Shared types and TPU address map for the TPU job sequencer.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR_C,
    LOAD_A,
    LOAD_B,
    START_MM,
    WAIT_MM,
    READ_C,
    DONE
  } state_t;

  localparam logic [15:0] A_BASE  = 16'h0100;
  localparam logic [15:0] B_BASE  = 16'h0200;
  localparam logic [15:0] C_BASE  = 16'h0300;
  localparam logic [15:0] MM_ADDR = 16'h0400;

  // Rows and half-rows sit on an 8-byte stride from their base address.
  function automatic logic [15:0] slot_addr(input logic [15:0] base, input logic [15:0] slot);
    return base + (slot << 3);
  endfunction

endpackage

// File: rtl/tpu_job_sequencer_if.sv
// Job control, input/output streams and TPU slave-port bus of the sequencer.
interface tpu_job_sequencer_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  start, in_valid, in_data, out_ready, tpu_rdata,
    output busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );

  modport slave (
    output start, in_valid, in_data, out_ready, tpu_rdata,
    input  busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );
endinterface

// File: rtl/tpu_seq_outbuf.sv
// One-entry valid/ready holding register; a load replaces the entry even while it is being drained.
module tpu_seq_outbuf #(
  parameter int DATAW = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DATAW-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data
);
  localparam int LANES = DATAW / 16;

  logic valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  // Data only moves on a load, so it stays frozen while the consumer stalls.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [15:0] lane_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= '0;
      end else if (load) begin
        lane_reg <= load_data[16*gi +: 16];
      end
    end

    assign out_data[16*gi +: 16] = lane_reg;
  end

  assign out_valid = valid_reg;

endmodule

// File: rtl/tpu_job_sequencer.sv
// Drives one matmul job through the TPU slave port: load A/B, trigger, wait, stream C back.
// Build option TPU_SEQ_CLEAR_C_EN zeroes the C buffer before each job instead of accumulating.
module tpu_job_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int DIM            = 8,
  parameter int ADDRW          = 16,
  parameter int DATAW          = 64,
  parameter int COMPUTE_CYCLES = 26
) (
  input logic                 clk,
  input logic                 rst,
  tpu_job_sequencer_if.master bus
);
  localparam int IDXW  = $clog2(2 * DIM);
  localparam int WCNTW = $clog2(COMPUTE_CYCLES + 1);

  state_t            state_reg, state_next;
  logic [IDXW-1:0]   idx_reg, idx_next;
  logic [WCNTW-1:0]  wcnt_reg, wcnt_next;
  logic              rd_done_reg, rd_done_next;

  logic              buf_load;
  logic              buf_valid;
  logic [DATAW-1:0]  buf_data;

  logic              busy_c, done_c, in_ready_c, r_w_c;
  logic [ADDRW-1:0]  addr_c;
  logic [DATAW-1:0]  wdata_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      wcnt_reg    <= '0;
      rd_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      wcnt_reg    <= wcnt_next;
      rd_done_reg <= rd_done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    wcnt_next    = wcnt_reg;
    rd_done_next = rd_done_reg;
    busy_c       = (state_reg != IDLE);
    done_c       = 1'b0;
    in_ready_c   = 1'b0;
    r_w_c        = 1'b0;
    addr_c       = '0;
    wdata_c      = '0;
    buf_load     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          idx_next     = '0;
          rd_done_next = 1'b0;
`ifdef TPU_SEQ_CLEAR_C_EN
          state_next   = CLEAR_C;
`else
          state_next   = LOAD_A;
`endif
        end
      end

      CLEAR_C: begin
        r_w_c  = 1'b1;
        addr_c = ADDRW'(slot_addr(C_BASE, 16'(idx_reg)));
        if (idx_reg == IDXW'(2 * DIM - 1)) begin
          idx_next   = '0;
          state_next = LOAD_A;
        end else begin
          idx_next = idx_reg + IDXW'(1);
        end
      end

      LOAD_A: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          r_w_c   = 1'b1;
          addr_c  = ADDRW'(slot_addr(A_BASE, 16'(idx_reg)));
          wdata_c = bus.in_data;
          if (idx_reg == IDXW'(DIM - 1)) begin
            idx_next   = '0;
            state_next = LOAD_B;
          end else begin
            idx_next = idx_reg + IDXW'(1);
          end
        end
      end

      // B words all go to one address; the TPU sequences them internally.
      LOAD_B: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          r_w_c   = 1'b1;
          addr_c  = ADDRW'(B_BASE);
          wdata_c = bus.in_data;
          if (idx_reg == IDXW'(DIM - 1)) begin
            idx_next   = '0;
            state_next = START_MM;
          end else begin
            idx_next = idx_reg + IDXW'(1);
          end
        end
      end

      START_MM: begin
        r_w_c      = 1'b1;
        addr_c     = ADDRW'(MM_ADDR);
        wcnt_next  = '0;
        state_next = WAIT_MM;
      end

      WAIT_MM: begin
        if (wcnt_reg == WCNTW'(COMPUTE_CYCLES - 1)) begin
          idx_next     = '0;
          rd_done_next = 1'b0;
          state_next   = READ_C;
        end else begin
          wcnt_next = wcnt_reg + WCNTW'(1);
        end
      end

      // A read is only issued when its result can be captured the same cycle.
      READ_C: begin
        if (!rd_done_reg && (!buf_valid || bus.out_ready)) begin
          addr_c   = ADDRW'(slot_addr(C_BASE, 16'(idx_reg)));
          buf_load = 1'b1;
          if (idx_reg == IDXW'(2 * DIM - 1)) begin
            rd_done_next = 1'b1;
          end else begin
            idx_next = idx_reg + IDXW'(1);
          end
        end
        if (rd_done_reg && buf_valid && bus.out_ready) begin
          state_next = DONE;
        end
      end

      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  tpu_seq_outbuf #(
    .DATAW(DATAW)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (bus.tpu_rdata),
    .out_ready (bus.out_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data)
  );

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = buf_valid;
  assign bus.out_data  = buf_data;
  assign bus.tpu_r_w   = r_w_c;
  assign bus.tpu_addr  = addr_c;
  assign bus.tpu_wdata = wdata_c;

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Randomized bench for tpu_job_sequencer with a behavioural TPU and a matrix reference model.
// Honours TPU_SEQ_CLEAR_C_EN: C is cleared per job when defined, accumulated otherwise.
module tb_tpu_job_sequencer;
  localparam int DIM   = 8;
  localparam int ADDRW = 16;
  localparam int DATAW = 64;
  localparam int CC    = 26;
  localparam int NW    = 2 * DIM;
`ifdef TPU_SEQ_CLEAR_C_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpu_job_sequencer_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  tpu_job_sequencer #(
    .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW), .COMPUTE_CYCLES(CC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural TPU slave: A/B storage, C buffer, matmul accumulates instantly.
  logic [63:0] a_mem [DIM];
  logic [63:0] b_mem [DIM];
  logic [63:0] c_mem [NW] = '{default: '0};
  int          b_ptr = 0;
  logic [63:0] rdata;

  always @(posedge clk) begin : tpu_model
    int wa;
    int acc;
    if (rst) begin
      b_ptr <= 0;
    end else if (bus.tpu_r_w) begin
      wa = int'(bus.tpu_addr);
      if (wa >= 'h0100 && wa < 'h0100 + 8 * DIM && wa % 8 == 0) begin
        a_mem[(wa - 'h0100) / 8] <= bus.tpu_wdata;
      end else if (wa == 'h0200) begin
        b_mem[b_ptr] <= bus.tpu_wdata;
        b_ptr <= (b_ptr + 1) % DIM;
      end else if (wa >= 'h0300 && wa < 'h0300 + 8 * NW && wa % 8 == 0) begin
        c_mem[(wa - 'h0300) / 8] <= bus.tpu_wdata;
      end else if (wa == 'h0400) begin
        for (int r = 0; r < DIM; r++) begin
          for (int j = 0; j < DIM; j++) begin
            acc = int'(c_mem[2 * r + j / 4][16 * (j % 4) +: 16]);
            for (int i = 0; i < DIM; i++) begin
              acc += int'(a_mem[r][8 * i +: 8]) * int'(b_mem[i][8 * j +: 8]);
            end
            c_mem[2 * r + j / 4][16 * (j % 4) +: 16] <= 16'(acc);
          end
        end
        b_ptr <= 0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.tpu_addr >= 16'h0300 && int'(bus.tpu_addr) < 'h0300 + 8 * NW && bus.tpu_addr[2:0] == 3'b000) begin
      rdata = c_mem[(int'(bus.tpu_addr) - 'h0300) / 8];
    end
  end
  assign bus.tpu_rdata = rdata;

  // Monitor: bus trace, output stream, done pulses and backpressure stability.
  logic [79:0] obs_wr [$];
  int          wr_cyc [$];
  logic [15:0] obs_rd [$];
  int          rd_cyc [$];
  logic [63:0] obs_out [$];
  int          done_cnt = 0;
  bit          hold_pend = 1'b0;
  logic [63:0] hold_data;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (bus.tpu_r_w) begin
        obs_wr.push_back({bus.tpu_addr, bus.tpu_wdata});
        wr_cyc.push_back(cyc);
      end else if (bus.tpu_addr != '0) begin
        obs_rd.push_back(bus.tpu_addr);
        rd_cyc.push_back(cyc);
      end
      if (hold_pend) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", bus.out_data, hold_data);
      end
      if (bus.out_valid && bus.out_ready) obs_out.push_back(bus.out_data);
      if (bus.done) done_cnt++;
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
    end
  end

  // Downstream ready: 0 = always, 1 = random, 2 = five-cycle stall after three words.
  int out_mode = 0;
  int job_id = 0;
  int out_base = 0;
  int stall_left = 0;
  int seen_job = 0;

  always @(posedge clk) begin
    #1;
    if (job_id != seen_job) begin
      seen_job = job_id;
      stall_left = 5;
    end
    case (out_mode)
      1: bus.out_ready = 1'($urandom_range(0, 1));
      2: begin
        if (obs_out.size() - out_base == 3 && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
      default: bus.out_ready = 1'b1;
    endcase
  end

  logic [63:0] arow [DIM];
  logic [63:0] bword [DIM];
  int a_b [DIM][DIM];
  int b_b [DIM][DIM];
  int ref_c [DIM][DIM];

  task automatic pack_job();
    for (int r = 0; r < DIM; r++) begin
      arow[r] = '0;
      bword[r] = '0;
      for (int i = 0; i < DIM; i++) begin
        arow[r][8 * i +: 8] = 8'(a_b[r][i]);
        bword[r][8 * i +: 8] = 8'(b_b[r][i]);
      end
    end
  endtask

  task automatic set_identity_twos();
    for (int r = 0; r < DIM; r++) begin
      for (int i = 0; i < DIM; i++) begin
        a_b[r][i] = (r == i) ? 1 : 0;
        b_b[r][i] = 2;
      end
    end
    pack_job();
  endtask

  task automatic set_random();
    for (int r = 0; r < DIM; r++) begin
      for (int i = 0; i < DIM; i++) begin
        a_b[r][i] = int'($urandom_range(0, 15));
        b_b[r][i] = int'($urandom_range(0, 15));
      end
    end
    pack_job();
  endtask

  // gap: 0 = back-to-back, 1 = one idle cycle between words, 2 = random 0-2 idle cycles.
  task automatic drive_words(input logic [63:0] w [DIM], input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int t;
      bit acc;
      if (i > 0 && gap != 0) begin
        bus.in_valid = 1'b0;
        if (gap == 1) begin
          @(posedge clk); #1;
        end else begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data = w[i];
      t = 0;
      acc = 1'b0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        t++;
      end
      check("in_accept", 64'(acc), 64'd1);
    end
    bus.in_valid = 1'b0;
    bus.in_data = '0;
  endtask

  task automatic run_job(input int id, input int gap_a, input int gap_b, input int omode,
                         input bit abort, input bit junk);
    logic [79:0] exp_wr [$];
    logic [63:0] ew;
    int nb, wr_base, rd_base, done0, t, s;
    nb = abort ? 4 : DIM;
    if (CLR) for (int k = 0; k < NW; k++) exp_wr.push_back({16'('h0300 + 8 * k), 64'd0});
    for (int r = 0; r < DIM; r++) exp_wr.push_back({16'('h0100 + 8 * r), arow[r]});
    for (int i = 0; i < nb; i++) exp_wr.push_back({16'h0200, bword[i]});
    if (!abort) exp_wr.push_back({16'h0400, 64'd0});

    wr_base = obs_wr.size();
    rd_base = obs_rd.size();
    out_base = obs_out.size();
    done0 = done_cnt;
    out_mode = omode;
    job_id = id;

    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_start", 64'(bus.busy), 64'd1);

    drive_words(arow, DIM, gap_a);
    drive_words(bword, nb, gap_b);

    if (abort) begin
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_r_w", 64'(bus.tpu_r_w), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
    end else begin
      if (junk) begin
        bus.in_valid = 1'b1;
        bus.in_data = 64'(($urandom()));
        bus.start = 1'b1;
        @(negedge clk);
        check("junk_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
      end
      t = 0;
      while (done_cnt == done0 && t < 3000) begin
        @(posedge clk); #1;
        t++;
      end
      check("done_seen", 64'(done_cnt - done0), 64'd1);
      check("busy_after_done", 64'(bus.busy), 64'd0);
      repeat (3) begin
        @(posedge clk); #1;
      end
      check("done_once", 64'(done_cnt - done0), 64'd1);

      for (int r = 0; r < DIM; r++) begin
        for (int j = 0; j < DIM; j++) begin
          s = 0;
          for (int i = 0; i < DIM; i++) s += a_b[r][i] * b_b[i][j];
          ref_c[r][j] = ((CLR ? 0 : ref_c[r][j]) + s) & 'hFFFF;
        end
      end
      check("out_count", 64'(obs_out.size() - out_base), 64'(NW));
      for (int k = 0; k < NW && out_base + k < obs_out.size(); k++) begin
        ew = '0;
        for (int l = 0; l < 4; l++) ew[16 * l +: 16] = 16'(ref_c[k / 2][(k % 2) * 4 + l]);
        check("c_word", obs_out[out_base + k], ew);
      end
      check("rd_count", 64'(obs_rd.size() - rd_base), 64'(NW));
      for (int k = 0; k < NW && rd_base + k < obs_rd.size(); k++) begin
        check("rd_addr", 64'(obs_rd[rd_base + k]), 64'('h0300 + 8 * k));
      end
      if (obs_rd.size() > rd_base && obs_wr.size() > wr_base) begin
        check("mm_to_read", 64'(rd_cyc[rd_base] - wr_cyc[obs_wr.size() - 1]), 64'(CC + 1));
      end
    end

    check("wr_count", 64'(obs_wr.size() - wr_base), 64'(exp_wr.size()));
    for (int k = 0; k < exp_wr.size() && wr_base + k < obs_wr.size(); k++) begin
      check("wr_addr", 64'(obs_wr[wr_base + k][79:64]), 64'(exp_wr[k][79:64]));
      check("wr_data", obs_wr[wr_base + k][63:0], exp_wr[k][63:0]);
    end
    $display("job %0d: abort=%0d writes=%0d reads=%0d words=%0d errors_so_far=%0d",
             id, abort, obs_wr.size() - wr_base, obs_rd.size() - rd_base,
             obs_out.size() - out_base, n_err);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_busy0", 64'(bus.busy), 64'd0);
    check("rst_out_valid0", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_r_w", 64'(bus.tpu_r_w), 64'd0);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_addr", 64'(bus.tpu_addr), 64'd0);
    check("idle_out_data", bus.out_data, 64'd0);

    set_identity_twos();
    run_job(1, 0, 0, 0, 1'b0, 1'b0);
    if (obs_out.size() > out_base) check("id2_row0", obs_out[out_base], 64'h0002000200020002);
    run_job(2, 1, 0, 0, 1'b0, 1'b1);
    set_random();
    run_job(3, 0, 2, 2, 1'b0, 1'b0);
    set_random();
    run_job(4, 2, 0, 0, 1'b1, 1'b0);
    set_random();
    run_job(5, 0, 0, 0, 1'b0, 1'b0);
    for (int n = 6; n < 9; n++) begin
      set_random();
      run_job(n, 2, 2, 1, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
